// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg
// Shared definitions for the decode/branch stage (id_branch_stage):
//   - bus widths between fetch, decode and execute
//   - major opcode constants (inst[31:26]) for the LoongArch branch group
//   - store opcode range (inst[31:22]) for st.b/st.h/st.w
//   - id_ex_t: field layout of the decode->execute bus
//   - decode helpers shared by the top level and the branch unit
// ---------------------------------------------------------------------------
package id_pkg;

    localparam int IF_ID_W = 64;
    localparam int ID_IF_W = 33;
    localparam int ID_EX_W = 133;

    localparam logic [5:0] OP_JIRL = 6'h13;
    localparam logic [5:0] OP_B    = 6'h14;
    localparam logic [5:0] OP_BL   = 6'h15;
    localparam logic [5:0] OP_BEQ  = 6'h16;
    localparam logic [5:0] OP_BNE  = 6'h17;
    localparam logic [5:0] OP_BLT  = 6'h18;
    localparam logic [5:0] OP_BGE  = 6'h19;
    localparam logic [5:0] OP_BLTU = 6'h1a;
    localparam logic [5:0] OP_BGEU = 6'h1b;

    localparam logic [9:0] OP_ST_B = 10'h0a4;
    localparam logic [9:0] OP_ST_W = 10'h0a6;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rj_value;
        logic [31:0] r2_value;
        logic [4:0]  dest;
    } id_ex_t;

    function automatic logic is_store(input logic [31:0] inst);
        return (inst[31:22] >= OP_ST_B) && (inst[31:22] <= OP_ST_W);
    endfunction

    // Conditional branches and stores use the rd field as a second source.
    function automatic logic reads_rd(input logic [31:0] inst);
        return ((inst[31:26] >= OP_BEQ) && (inst[31:26] <= OP_BGEU)) || is_store(inst);
    endfunction

endpackage

// File: rtl/id_branch_stage_if.sv
// ---------------------------------------------------------------------------
// id_branch_stage_if
// Pipeline handshake bundle around the decode stage.
//   if_id_valid / if_id_bus  : fetch -> decode  {pc, inst}
//   id_allowin               : decode -> fetch  accept this cycle
//   id_if_bus                : decode -> fetch  {br_taken, br_target}
//   ex_allowin               : execute -> decode accept this cycle
//   id_ex_valid / id_ex_bus  : decode -> execute {pc, inst, rj, r2, dest}
// Modports:
//   master : the decode stage
//   slave  : the surrounding pipeline (fetch + execute side)
// ---------------------------------------------------------------------------
interface id_branch_stage_if;
    import id_pkg::*;

    logic               if_id_valid;
    logic [IF_ID_W-1:0] if_id_bus;
    logic               id_allowin;
    logic [ID_IF_W-1:0] id_if_bus;
    logic               ex_allowin;
    logic               id_ex_valid;
    logic [ID_EX_W-1:0] id_ex_bus;

    modport master (
        input  if_id_valid, if_id_bus, ex_allowin,
        output id_allowin, id_if_bus, id_ex_valid, id_ex_bus
    );

    modport slave (
        output if_id_valid, if_id_bus, ex_allowin,
        input  id_allowin, id_if_bus, id_ex_valid, id_ex_bus
    );

endinterface

// File: rtl/id_br_unit.sv
// ---------------------------------------------------------------------------
// id_br_unit
// Purely combinational LoongArch branch resolution and destination decode.
// Ports:
//   pc, inst           : instruction held in decode
//   rj_value, r2_value : source operands (r2 is rd for branches)
//   cond               : branch/jump would be taken (not yet gated)
//   target             : branch/jump target address
//   dest               : destination register, 0 = no write
// ---------------------------------------------------------------------------
module id_br_unit
    import id_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [31:0] rj_value,
    input  logic [31:0] r2_value,
    output logic        cond,
    output logic [31:0] target,
    output logic [4:0]  dest
);

    logic signed [31:0] rj_s;
    logic signed [31:0] r2_s;
    logic        [31:0] offs16_ext;
    logic        [31:0] offs26_ext;

    assign rj_s = rj_value;
    assign r2_s = r2_value;

    // Word offsets: sign-extend the immediate and scale by 4.
    assign offs16_ext = {{14{inst[25]}}, inst[25:10], 2'b00};
    assign offs26_ext = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};

    always_comb begin
        cond   = 1'b0;
        target = pc + offs16_ext;
        dest   = inst[4:0];
        unique case (inst[31:26])
            OP_JIRL: begin
                cond   = 1'b1;
                target = rj_value + offs16_ext;
            end
            OP_B: begin
                cond   = 1'b1;
                target = pc + offs26_ext;
                dest   = 5'd0;
            end
            OP_BL: begin
                cond   = 1'b1;
                target = pc + offs26_ext;
                dest   = 5'd1;
            end
            // Conditional branches read rd as a source and write nothing.
            OP_BEQ:  begin cond = (rj_value == r2_value); dest = 5'd0; end
            OP_BNE:  begin cond = (rj_value != r2_value); dest = 5'd0; end
            OP_BLT:  begin cond = (rj_s <  r2_s);         dest = 5'd0; end
            OP_BGE:  begin cond = (rj_s >= r2_s);         dest = 5'd0; end
            OP_BLTU: begin cond = (rj_value <  r2_value); dest = 5'd0; end
            OP_BGEU: begin cond = (rj_value >= r2_value); dest = 5'd0; end
            default: begin
                if (is_store(inst)) begin
                    dest = 5'd0;
                end
            end
        endcase
    end

endmodule

// File: rtl/id_branch_stage.sv
// ---------------------------------------------------------------------------
// id_branch_stage
// Decode stage directly after fetch: latches {pc, inst}, reads the register
// file, stalls on RAW hazards against EX/MEM/WB, resolves branches back to
// fetch and hands operands to EX over a valid/allowin handshake.
// Ports:
//   clk, resetn                 : clock, asynchronous active-low reset
//   pipe (master)               : fetch/execute handshake bundle
//   rf_raddr1/2, rf_rdata1/2    : register-file read port (combinational)
//   ex_dest, mem_dest, wb_dest  : downstream destinations (0 = none)
//   ex_is_load                  : EX holds a load
//   ex_fwd, mem_fwd, wb_fwd     : downstream results (bypass build only)
//   flush                       : exception / ertn flush
// Build option: define ID_BYPASS_EN to forward downstream results and stall
// only on a load-use dependency; otherwise any dependency stalls.
// ---------------------------------------------------------------------------
module id_branch_stage
    import id_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1bfffffc
) (
    input  logic               clk,
    input  logic               resetn,
    id_branch_stage_if.master  pipe,
    output logic [4:0]         rf_raddr1,
    output logic [4:0]         rf_raddr2,
    input  logic [31:0]        rf_rdata1,
    input  logic [31:0]        rf_rdata2,
    input  logic [4:0]         ex_dest,
    input  logic [4:0]         mem_dest,
    input  logic [4:0]         wb_dest,
    input  logic               ex_is_load,
    input  logic [31:0]        ex_fwd,
    input  logic [31:0]        mem_fwd,
    input  logic [31:0]        wb_fwd,
    input  logic               flush
);

    logic        id_vld_p0;
    logic [31:0] id_pc_p0;
    logic [31:0] id_inst_p0;

    logic [31:0] rj_value;
    logic [31:0] r2_value;
    logic        stall;
    logic        id_ready_go;
    logic        id_allowin;
    logic        br_cond;
    logic        br_taken;
    logic [31:0] br_target;
    logic [4:0]  dest;
    id_ex_t      ex_pkt;

    function automatic logic reg_hit(input logic [4:0] raddr, input logic [4:0] wdest);
        return (raddr != 5'd0) && (raddr == wdest);
    endfunction

    // ---- fetch -> decode boundary ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_vld_p0  <= 1'b0;
            id_pc_p0   <= RESET_PC;
            id_inst_p0 <= 32'd0;
        end else if (flush) begin
            id_vld_p0  <= 1'b0;
        end else if (id_allowin) begin
            // A taken branch leaving this cycle squashes its wrong-path successor.
            id_vld_p0  <= pipe.if_id_valid & ~br_taken;
            id_pc_p0   <= pipe.if_id_bus[63:32];
            id_inst_p0 <= pipe.if_id_bus[31:0];
        end
    end

    assign rf_raddr1 = id_inst_p0[9:5];
    assign rf_raddr2 = reads_rd(id_inst_p0) ? id_inst_p0[4:0] : id_inst_p0[14:10];

`ifdef ID_BYPASS_EN
    // Later assignments win, so the youngest producer (EX) takes priority.
    always_comb begin
        rj_value = rf_rdata1;
        if (reg_hit(rf_raddr1, wb_dest))  rj_value = wb_fwd;
        if (reg_hit(rf_raddr1, mem_dest)) rj_value = mem_fwd;
        if (reg_hit(rf_raddr1, ex_dest))  rj_value = ex_fwd;
        r2_value = rf_rdata2;
        if (reg_hit(rf_raddr2, wb_dest))  r2_value = wb_fwd;
        if (reg_hit(rf_raddr2, mem_dest)) r2_value = mem_fwd;
        if (reg_hit(rf_raddr2, ex_dest))  r2_value = ex_fwd;
    end

    // Only a load in EX has no result to forward yet.
    assign stall = ex_is_load &
                   (reg_hit(rf_raddr1, ex_dest) | reg_hit(rf_raddr2, ex_dest));
`else
    logic unused_fwd;

    assign rj_value   = rf_rdata1;
    assign r2_value   = rf_rdata2;
    assign unused_fwd = ^{ex_is_load, ex_fwd, mem_fwd, wb_fwd};

    // Both addresses are checked even when the instruction ignores one;
    // the occasional extra stall keeps the decode simple.
    assign stall = reg_hit(rf_raddr1, ex_dest) | reg_hit(rf_raddr1, mem_dest) |
                   reg_hit(rf_raddr1, wb_dest) | reg_hit(rf_raddr2, ex_dest)  |
                   reg_hit(rf_raddr2, mem_dest) | reg_hit(rf_raddr2, wb_dest);
`endif

    id_br_unit u_br_unit (
        .pc       (id_pc_p0),
        .inst     (id_inst_p0),
        .rj_value (rj_value),
        .r2_value (r2_value),
        .cond     (br_cond),
        .target   (br_target),
        .dest     (dest)
    );

    assign id_ready_go = ~stall;
    assign id_allowin  = ~id_vld_p0 | (id_ready_go & pipe.ex_allowin);
    // The redirect is only raised when the branch actually moves on to EX.
    assign br_taken    = br_cond & id_vld_p0 & id_ready_go & pipe.ex_allowin & ~flush;

    assign ex_pkt.pc       = id_pc_p0;
    assign ex_pkt.inst     = id_inst_p0;
    assign ex_pkt.rj_value = rj_value;
    assign ex_pkt.r2_value = r2_value;
    assign ex_pkt.dest     = dest;

    // ---- decode -> execute / fetch boundary ----
    assign pipe.id_allowin  = id_allowin;
    assign pipe.id_if_bus   = {br_taken, br_target};
    assign pipe.id_ex_valid = id_vld_p0 & id_ready_go & ~flush;
    assign pipe.id_ex_bus   = ex_pkt;

endmodule

// File: doc/id_branch_stage.md
Name: id_branch_stage

Overview:
- Decode stage that sits directly downstream of the fetch stage.
- Latches {pc, inst} from fetch and reads the register file.
- Detects RAW hazards against EX/MEM/WB and stalls when one is found.
- Resolves all LoongArch branches, returns {br_taken, br_target} to fetch, and hands operands to EX over a valid/allowin handshake.

Parameters:
- RESET_PC, 32'h1bfffffc, value of the latched PC while reset is active (debug visibility only).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- if_id_valid  in  1  fetch holds a valid instruction
- if_id_bus  in  64  {pc[31:0], inst[31:0]}
- id_allowin  out  1  decode can accept this cycle
- id_if_bus  out  33  {br_taken, br_target[31:0]}
- ex_allowin  in  1  EX can accept
- id_ex_valid  out  1  decode output valid
- id_ex_bus  out  133  {pc, inst, rj_value, r2_value, dest[4:0]}
- rf_raddr1, rf_raddr2  out  5  register-file read addresses
- rf_rdata1, rf_rdata2  in  32  register-file read data, combinational
- ex_dest, mem_dest, wb_dest  in  5  destination register of each downstream stage (0 = none or invalid)
- ex_is_load  in  1  EX holds a load
- ex_fwd, mem_fwd, wb_fwd  in  32  results of those stages (used only under BYPASS_EN)
- flush  in  1  exception or ertn flush (wb_ex | ertn_flush)

Behaviour:
- Reset (async, resetn=0):
  - id_valid=0, id_pc=RESET_PC, id_inst=0.
  - Therefore id_ex_valid=0 and br_taken=0.
- Source registers:
  - rf_raddr1 = inst[9:5] (rj).
  - rf_raddr2 = inst[4:0] (rd) when opcode inst[31:26] is in 0x16–0x1b, or for st.b/st.h/st.w (inst[31:22] = 0x0a4–0x0a6).
  - Otherwise rf_raddr2 = inst[14:10] (rk).
- Hazard:
  - Applies only to a nonzero raddr equal to a nonzero ex_dest/mem_dest/wb_dest.
  - Checked on both read addresses regardless of actual use; the resulting over-stall is accepted.
  - Any hazard sets stall=1.
- Handshake:
  - id_ready_go = ~stall.
  - id_allowin = ~id_valid | (id_ready_go & ex_allowin).
  - id_ex_valid = id_valid & id_ready_go & ~flush.
- Latch, on clk edge:
  - flush: id_valid <= 0, regardless of every other input.
  - Otherwise, if id_allowin: id_valid <= if_id_valid & ~br_taken, and id_pc/id_inst <= if_id_bus.
  - Masking with br_taken squashes the wrong-path instruction fetched alongside a taken branch.
- Branch resolution (combinational; compares use rj_value vs r2_value):
  - 0x13 jirl: taken; target = rj + sext({offs16,2'b0}); dest = rd.
  - 0x14 b: taken; target = pc + sext({offs26,2'b0}); dest = 0.
  - 0x15 bl: taken; target as b; dest = 1.
  - 0x16 beq (==), 0x17 bne (!=): target = pc + sext({offs16,2'b0}).
  - 0x18 blt (signed <), 0x19 bge (signed >=): same target.
  - 0x1a bltu (unsigned <), 0x1b bgeu (unsigned >=): same target.
  - Field definitions: offs16 = inst[25:10]; offs26 = {inst[9:0], inst[25:10]}. All adds are 32-bit and wrap.
- br_taken gating:
  - br_taken = cond & id_valid & id_ready_go & ex_allowin & ~flush.
  - br_taken is never raised while stalled.
- dest for non-branches:
  - 0 for stores.
  - rd for all other instructions.
  - Value 0 means no write.
- Simultaneous flush and taken branch: flush wins; br_taken=0.

Optional Feature:
- Macro: ID_BYPASS_EN.
- Defined:
  - rj_value/r2_value take the youngest matching ex_fwd > mem_fwd > wb_fwd, else rf_rdata.
  - stall only when ex_is_load and ex_dest matches a nonzero source.
- Undefined:
  - values come straight from rf_rdata.
  - stall on any match as described above.
  - fwd inputs are ignored.

Decomposition:
- Shared package (id_pkg):
  - opcode constants OP_JIRL..OP_BGEU.
  - bus widths IF_ID_W=64, ID_IF_W=33, ID_EX_W=133.
- One sub-module, id_br_unit: purely combinational; takes pc, inst, rj_value, r2_value; produces cond, target, dest.

Test Plan:
- Straight-line flow:
  - Stimulus: pc 0x1c000000, add.w r4,r5,r6, no hazards, ex_allowin=1.
  - Required: id_ex_valid one cycle after acceptance; raddr1=5, raddr2=6, dest=4.
- Taken beq:
  - Stimulus: rj=rd=0x10, offs16=4.
  - Required: br_taken=1, target=pc+0x10; the next fetched instruction is latched with id_valid=0.
- Not-taken bltu:
  - Stimulus: rj=5, rd=3.
  - Required: br_taken=0; the next instruction proceeds.
- RAW stall (no bypass):
  - Stimulus: ex_dest=5, raddr1=5.
  - Required: id_allowin=0 and id_ex_valid=0 until ex_dest clears; no br_taken during the stall.
- Bypass build:
  - Stimulus: mem_dest=5, mem_fwd=0xdead.
  - Required: rj_value=0xdead with no stall.
  - Stimulus: ex_is_load with ex_dest=5.
  - Required: stall for one cycle.
- Flush and reset:
  - Stimulus: flush together with a taken jirl.
  - Required: br_taken=0; id_valid=0 next cycle.
  - Stimulus: async resetn low mid-stall.
  - Required: id_ex_valid=0 immediately.
